// File: rtl/ws2812b_pkg.sv
// ----------------------------------------------------------------------------
// ws2812b_pkg
// Constants and types shared by the WS2812B strip controller and the frame
// generator that feeds it.
//   CLK_HZ       system clock frequency (clk_50)
//   FRAME_MIN    shortest frame period, in clk_50 cycles, that still lets the
//                controller finish shifting a full strip before the next
//                frame arrives
//   *_CYC        WS2812B line timing in clk_50 cycles, used by the controller
//   bar_state_t  sequencing states of the bar frame generator
// ----------------------------------------------------------------------------
package ws2812b_pkg;

    localparam int unsigned CLK_HZ    = 50_000_000;
    localparam int unsigned FRAME_MIN = 75_000;

    // WS2812B line timing at 50 MHz (20 ns per cycle).
    localparam int unsigned T0H_CYC   = 20;     // 400 ns high for a '0'
    localparam int unsigned T1H_CYC   = 40;     // 800 ns high for a '1'
    localparam int unsigned BIT_CYC   = 63;     // ~1.25 us per bit
    localparam int unsigned RESET_CYC = 2_500;  // 50 us latch gap

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        SCALE  = 2'd1,
        UPDATE = 2'd2,
        EMIT   = 2'd3
    } bar_state_t;

endpackage

// File: rtl/ws2812b_bar_frame_gen_therm.sv
// ----------------------------------------------------------------------------
// bar_therm_encode
// Combinational thermometer encoder: the lowest 'count' bits of 'therm' are
// set, all others clear. A count of N or more lights the whole bar.
//   count  in   CW  number of lit LEDs, 0..N
//   therm  out  N   bit 0 = bottom LED
// ----------------------------------------------------------------------------
module bar_therm_encode #(
    parameter  int N  = 32,
    localparam int CW = $clog2(N + 1)
) (
    input  logic [CW-1:0] count,
    output logic [N-1:0]  therm
);

    always_comb begin
        for (int i = 0; i < N; i++) begin
            therm[i] = (count > CW'(i));
        end
    end

endmodule

// File: rtl/ws2812b_bar_frame_gen.sv
// ----------------------------------------------------------------------------
// ws2812b_bar_frame_gen
// Turns a stream of level samples into an N-LED bar graph with instant
// attack, one-LED-per-frame decay and a floating peak-hold dot. The output
// is refreshed once per frame period so the downstream WS2812B controller is
// never re-triggered faster than it can serialise a strip.
//   clk_50       in   1   50 MHz clock
//   rst          in   1   synchronous, active-high reset
//   level_in     in   LW  unsigned level sample
//   level_valid  in   1   level_in qualifier, one sample per high cycle
//   bar_out      out  N   LED on/off pattern, bit 0 = bottom LED
//   frame_valid  out  1   one-cycle pulse when bar_out updates
// FRAME_DIV is clk_50 cycles per frame; real hardware needs
// FRAME_DIV >= FRAME_MIN, smaller values are for simulation only.
// ----------------------------------------------------------------------------
module ws2812b_bar_frame_gen
    import ws2812b_pkg::*;
#(
    parameter int N           = 32,
    parameter int LW          = 8,
    parameter int FRAME_DIV   = 100_000,
    parameter int HOLD_FRAMES = 4
) (
    input  logic          clk_50,
    input  logic          rst,
    input  logic [LW-1:0] level_in,
    input  logic          level_valid,
    output logic [N-1:0]  bar_out,
    output logic          frame_valid
);

    localparam int CW  = $clog2(N + 1);
    localparam int FCW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int HW  = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    // (2^LW-1)*(N+1) < 2^(LW+CW), so the rounded product never overflows.
    localparam int PW  = LW + CW;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [FCW-1:0] frame_cnt_q,   frame_cnt_d;
    logic [LW-1:0]  acc_max_q,     acc_max_d;
    logic [LW-1:0]  acc_snap_q,    acc_snap_d;
    bar_state_t     state_q,       state_d;
    logic [CW-1:0]  lit_q,         lit_d;
    logic [CW-1:0]  bar_cnt_q,     bar_cnt_d;
    logic [CW-1:0]  peak_pos_q,    peak_pos_d;
    logic [HW-1:0]  hold_cnt_q,    hold_cnt_d;
    logic [N-1:0]   bar_out_q,     bar_out_d;
    logic           frame_valid_q, frame_valid_d;

    logic           frame_tick;
    logic [PW-1:0]  scaled;
    logic [CW-1:0]  bar_next;
    logic [N-1:0]   bar_therm;
    logic [N-1:0]   peak_dot;

    // ------------------------------------------------------------------------
    // Frame timebase and per-frame peak accumulation
    // ------------------------------------------------------------------------
    assign frame_tick = (frame_cnt_q == FCW'(FRAME_DIV - 1));

    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        frame_cnt_d = frame_cnt_q + 1'b1;
        acc_max_d   = acc_max_q;
        acc_snap_d  = acc_snap_q;

        if (frame_tick) begin
            frame_cnt_d = '0;
            acc_snap_d  = acc_max_q;
            // A sample on the tick cycle starts the next frame.
            acc_max_d   = level_valid ? level_in : '0;
        end else if (level_valid && (level_in > acc_max_q)) begin
            acc_max_d   = level_in;
        end
    end

    // ------------------------------------------------------------------------
    // Scaling: ceil(acc_snap * N / 2^LW), so any nonzero level lights at
    // least one LED and full scale lights exactly N.
    // ------------------------------------------------------------------------
    assign scaled = PW'(acc_snap_q) * PW'(N) + PW'((1 << LW) - 1);

    // Instant attack, one-step decay.
    assign bar_next = (lit_q >= bar_cnt_q) ? lit_q : (bar_cnt_q - 1'b1);

    bar_therm_encode #(.N(N)) u_therm (
        .count (bar_cnt_q),
        .therm (bar_therm)
    );

    // Peak dot sits on LED peak_pos-1; position 0 means no dot.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            peak_dot[i] = (peak_pos_q == CW'(i + 1));
        end
    end

    // ------------------------------------------------------------------------
    // Frame sequencer: ACCUM -> SCALE -> UPDATE -> EMIT -> ACCUM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        lit_d         = lit_q;
        bar_cnt_d     = bar_cnt_q;
        peak_pos_d    = peak_pos_q;
        hold_cnt_d    = hold_cnt_q;
        bar_out_d     = bar_out_q;
        frame_valid_d = 1'b0;

        unique case (state_q)
            ACCUM: begin
                if (frame_tick) begin
                    state_d = SCALE;
                end
            end

            SCALE: begin
                lit_d   = scaled[PW-1:LW];
                state_d = UPDATE;
            end

            UPDATE: begin
                bar_cnt_d = bar_next;
                if (bar_next >= peak_pos_q) begin
                    peak_pos_d = bar_next;
                    hold_cnt_d = HW'(HOLD_FRAMES);
                end else if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end else begin
                    // bar_next < peak_pos_q here, so peak_pos_q >= 1.
                    peak_pos_d = peak_pos_q - 1'b1;
                end
                state_d = EMIT;
            end

            EMIT: begin
                bar_out_d     = bar_therm | peak_dot;
                frame_valid_d = 1'b1;
                state_d       = ACCUM;
            end

            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: non-blocking assignments here so every flop samples the values
    // computed from the previous cycle, independent of statement order.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            frame_cnt_q   <= '0;
            acc_max_q     <= '0;
            acc_snap_q    <= '0;
            state_q       <= ACCUM;
            lit_q         <= '0;
            bar_cnt_q     <= '0;
            peak_pos_q    <= '0;
            hold_cnt_q    <= '0;
            bar_out_q     <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            acc_max_q     <= acc_max_d;
            acc_snap_q    <= acc_snap_d;
            state_q       <= state_d;
            lit_q         <= lit_d;
            bar_cnt_q     <= bar_cnt_d;
            peak_pos_q    <= peak_pos_d;
            hold_cnt_q    <= hold_cnt_d;
            bar_out_q     <= bar_out_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign bar_out     = bar_out_q;
    assign frame_valid = frame_valid_q;

endmodule
